spram_arb: RTL and testbench
============================

Name: spram_arb

Overview:
- Two-requester arbiter that shares one single-port RAM (spram: 1-cycle registered read, write-first-irrelevant since read/write never coincide per access) between port A (e.g. ibuf loader) and port B (e.g. compute reader).
- Per-cycle req/gnt handshake; registers the winning command onto the RAM pins; routes returned read data to the owning port with a per-port valid.
- Sits between the AXI-load/main-process blocks and one spram instance.

Parameters:
- ASIZE, 10, RAM address width (matches spram ASIZE)
- DSIZE, 32, RAM data width (matches spram DSIZE)
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (A always wins)

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  synchronous active-low reset
- I_a_req  in  1  port A access request
- I_a_wr  in  1  port A: 1 = write, 0 = read
- I_a_addr  in  ASIZE  port A address
- I_a_wdata  in  DSIZE  port A write data
- O_a_gnt  out  1  port A grant (combinational); transfer when I_a_req & O_a_gnt
- O_a_rdata  out  DSIZE  read data (shared with B)
- O_a_rvld  out  1  port A read data valid
- I_b_req, I_b_wr, I_b_addr, I_b_wdata, O_b_gnt, O_b_rdata, O_b_rvld: same as A, for port B
- O_ram_addr  out  ASIZE  to spram I_addr
- O_ram_data  out  DSIZE  to spram I_data
- O_ram_wr  out  1  to spram I_wr
- I_ram_rdata  in  DSIZE  from spram O_data

Behaviour:
- Grant (combinational, from I_*_req and last-winner register): only one port ever granted; O_x_gnt never high without I_x_req.
- PRIO_MODE=0: both requesting -> grant the port that did not win the most recent accepted transfer; single requester always granted immediately. last_winner updates only on an accepted transfer.
- PRIO_MODE=1: A granted whenever I_a_req; B granted only when !I_a_req.
- Accept cycle c (req & gnt). At edge ending c: O_ram_addr <= winner addr, O_ram_data <= winner wdata, O_ram_wr <= winner wr. Cycle with no accept: O_ram_wr <= 0, O_ram_addr/O_ram_data hold previous values.
- Read return: 2-stage tag pipeline {vld, owner}. Read accepted in cycle c -> O_x_rvld = 1 for exactly one cycle in c+2; O_x_rdata = I_ram_rdata in that cycle. O_a_rdata and O_b_rdata are both wired to I_ram_rdata; only rvld distinguishes.
- Writes produce no rvld. Back-to-back reads: one accepted read per cycle sustained, rvld in consecutive cycles in accept order.
- Throughput: 1 access/cycle total; no bubbles between owners.
- Requester may drop req without being granted (no lock); address/data sampled only in accept cycle.
- Reset (I_rst_n=0 at a clock edge): O_ram_wr=0, O_ram_addr=0, O_ram_data=0, tag pipeline cleared (O_a_rvld=O_b_rvld=0), last_winner=B (so A wins first contention). Grants are forced 0 while I_rst_n=0. Reads in flight at reset are dropped: no rvld after reset.
- Simultaneous write A / read B at same address: serialized by arbitration; read returns the value per program order of accepts (write accepted first -> read sees new data).

Test Plan:
- Reset: hold I_rst_n=0 3 cycles with both req high -> gnt=0, O_ram_wr=0, rvld=0; release -> A granted first cycle.
- Single port: A writes 0xDEADBEEF @0x005 (cycle c), then reads @0x005 at c+1 -> O_ram_wr=1 in c+1, O_a_rvld=1 in c+3 with O_a_rdata=0xDEADBEEF, O_b_rvld=0.
- Round-robin: both req continuously reading addrs A:0x010.., B:0x020.. for 8 cycles -> gnt alternates A,B,A,B; rvld alternates starting 2 cycles later, data matches preloaded contents.
- Fixed priority (PRIO_MODE=1): both req 5 cycles -> B never granted; drop A -> B granted same cycle.
- Ordering: A writes 0x12345678 @0x3FF, B reads @0x3FF next cycle -> O_b_rdata=0x12345678 with O_b_rvld 2 cycles after B accept.
- Reset mid-flight: B read accepted cycle c, I_rst_n=0 in c+1 -> no O_b_rvld in c+2 or later.

Source files
------------

// File: rtl/spram_arb.sv
// Two-port arbiter in front of one single-port RAM: per-cycle req/gnt handshake,
// registered RAM command pins, and a 2-stage tag pipeline that steers read data back.
module spram_arb #(
  parameter int ASIZE     = 10,
  parameter int DSIZE     = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_a_req,
  input  logic             I_a_wr,
  input  logic [ASIZE-1:0] I_a_addr,
  input  logic [DSIZE-1:0] I_a_wdata,
  output logic             O_a_gnt,
  output logic [DSIZE-1:0] O_a_rdata,
  output logic             O_a_rvld,
  input  logic             I_b_req,
  input  logic             I_b_wr,
  input  logic [ASIZE-1:0] I_b_addr,
  input  logic [DSIZE-1:0] I_b_wdata,
  output logic             O_b_gnt,
  output logic [DSIZE-1:0] O_b_rdata,
  output logic             O_b_rvld,
  output logic [ASIZE-1:0] O_ram_addr,
  output logic [DSIZE-1:0] O_ram_data,
  output logic             O_ram_wr,
  input  logic [DSIZE-1:0] I_ram_rdata
);

  // last_b_q = 1 means B won the most recent accepted transfer
  logic             last_b_q, last_b_d;
  logic [ASIZE-1:0] ram_addr_q, ram_addr_d;
  logic [DSIZE-1:0] ram_data_q, ram_data_d;
  logic             ram_wr_q, ram_wr_d;
  logic             tag1_vld_q, tag1_vld_d, tag1_own_q, tag1_own_d;
  logic             tag2_vld_q, tag2_own_q;
  logic             a_gnt, b_gnt, acc_a, acc_b;

  // Grant decision
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!I_rst_n) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end else if (PRIO_MODE != 0) begin
      a_gnt = I_a_req;
      b_gnt = I_b_req & ~I_a_req;
    end else if (I_a_req && I_b_req) begin
      a_gnt = last_b_q;
      b_gnt = ~last_b_q;
    end else begin
      a_gnt = I_a_req;
      b_gnt = I_b_req;
    end
  end

  assign acc_a = I_a_req & a_gnt;
  assign acc_b = I_b_req & b_gnt;

  // Next-state for RAM command pins, winner history and first tag stage
  always_comb begin
    last_b_d   = last_b_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wr_d   = 1'b0;
    tag1_vld_d = 1'b0;
    tag1_own_d = 1'b0;
    if (acc_a) begin
      last_b_d   = 1'b0;
      ram_addr_d = I_a_addr;
      ram_data_d = I_a_wdata;
      ram_wr_d   = I_a_wr;
      tag1_vld_d = ~I_a_wr;
      tag1_own_d = 1'b0;
    end else if (acc_b) begin
      last_b_d   = 1'b1;
      ram_addr_d = I_b_addr;
      ram_data_d = I_b_wdata;
      ram_wr_d   = I_b_wr;
      tag1_vld_d = ~I_b_wr;
      tag1_own_d = 1'b1;
    end else begin
      ram_wr_d   = 1'b0;
      tag1_vld_d = 1'b0;
    end
  end

  // State registers; reset drops any reads in flight
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      last_b_q   <= 1'b1;
      ram_addr_q <= {ASIZE{1'b0}};
      ram_data_q <= {DSIZE{1'b0}};
      ram_wr_q   <= 1'b0;
      tag1_vld_q <= 1'b0;
      tag1_own_q <= 1'b0;
      tag2_vld_q <= 1'b0;
      tag2_own_q <= 1'b0;
    end else begin
      last_b_q   <= last_b_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wr_q   <= ram_wr_d;
      tag1_vld_q <= tag1_vld_d;
      tag1_own_q <= tag1_own_d;
      tag2_vld_q <= tag1_vld_q;
      tag2_own_q <= tag1_own_q;
    end
  end

  assign O_a_gnt    = a_gnt;
  assign O_b_gnt    = b_gnt;
  assign O_ram_addr = ram_addr_q;
  assign O_ram_data = ram_data_q;
  assign O_ram_wr   = ram_wr_q;
  assign O_a_rdata  = I_ram_rdata;
  assign O_b_rdata  = I_ram_rdata;
  assign O_a_rvld   = tag2_vld_q & ~tag2_own_q;
  assign O_b_rvld   = tag2_vld_q & tag2_own_q;

endmodule

// File: tb/tb_spram_arb.sv
// Scoreboard bench for spram_arb: behavioural spram, reference grant/RAM-pin model,
// and a queue of expected read returns checked against the per-port valids.
module tb_spram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_wr, b_req, b_wr;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvld, b_gnt, b_rvld;
  logic [31:0] a_rdata, b_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_data, ram_rdata;
  logic        ram_wr;

  logic        fp_a_gnt, fp_b_gnt, fp_a_rvld, fp_b_rvld, fp_ram_wr;
  logic [31:0] fp_a_rdata, fp_b_rdata, fp_ram_data;
  logic [9:0]  fp_ram_addr;
  logic [31:0] fp_ram_rdata = 32'h0;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_mem [0:1023];

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        m_last_b;
  logic [9:0]  m_ram_addr;
  logic [31:0] m_ram_data;
  logic        m_ram_wr;

  spram_arb #(.ASIZE(10), .DSIZE(32), .PRIO_MODE(0)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_a_req(a_req), .I_a_wr(a_wr), .I_a_addr(a_addr), .I_a_wdata(a_wdata),
    .O_a_gnt(a_gnt), .O_a_rdata(a_rdata), .O_a_rvld(a_rvld),
    .I_b_req(b_req), .I_b_wr(b_wr), .I_b_addr(b_addr), .I_b_wdata(b_wdata),
    .O_b_gnt(b_gnt), .O_b_rdata(b_rdata), .O_b_rvld(b_rvld),
    .O_ram_addr(ram_addr), .O_ram_data(ram_data), .O_ram_wr(ram_wr),
    .I_ram_rdata(ram_rdata)
  );

  spram_arb #(.ASIZE(10), .DSIZE(32), .PRIO_MODE(1)) dut_fp (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_a_req(a_req), .I_a_wr(a_wr), .I_a_addr(a_addr), .I_a_wdata(a_wdata),
    .O_a_gnt(fp_a_gnt), .O_a_rdata(fp_a_rdata), .O_a_rvld(fp_a_rvld),
    .I_b_req(b_req), .I_b_wr(b_wr), .I_b_addr(b_addr), .I_b_wdata(b_wdata),
    .O_b_gnt(fp_b_gnt), .O_b_rdata(fp_b_rdata), .O_b_rvld(fp_b_rvld),
    .O_ram_addr(fp_ram_addr), .O_ram_data(fp_ram_data), .O_ram_wr(fp_ram_wr),
    .I_ram_rdata(fp_ram_rdata)
  );

  always #5 clk = ~clk;

  // single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_data;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // read-return monitor: pops entries due two cycles after their accept
  always @(negedge clk) begin
    logic ea, eb;
    logic [31:0] ed;
    ea = 1'b0;
    eb = 1'b0;
    ed = 32'h0;
    if (exp_q.size() > 0 && exp_q[0].cyc + 2 == cyc) begin
      ed = exp_q[0].data;
      if (exp_q[0].port) eb = 1'b1;
      else ea = 1'b1;
      void'(exp_q.pop_front());
    end
    if (rst_n !== 1'b0 || a_rvld !== 1'b0 || b_rvld !== 1'b0 || ea || eb) begin
      check_eq("a_rvld", {31'h0, a_rvld}, {31'h0, ea});
      check_eq("b_rvld", {31'h0, b_rvld}, {31'h0, eb});
      if (ea) check_eq("a_rdata", a_rdata, ed);
      if (eb) check_eq("b_rdata", b_rdata, ed);
    end
  end

  // one bus cycle: drive, check grants and RAM pins against the model, advance
  task automatic step(input logic rst, input logic ar, input logic aw, input logic [9:0] aa,
                      input logic [31:0] ad, input logic br, input logic bw,
                      input logic [9:0] ba, input logic [31:0] bd,
                      output logic ga, output logic gb);
    logic fa, fb;
    rst_n = rst; a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[$].cyc + 2 != cyc) void'(exp_q.pop_back());
    end
    @(negedge clk);
    check_eq("ram_wr", {31'h0, ram_wr}, {31'h0, m_ram_wr});
    check_eq("ram_addr", {22'h0, ram_addr}, {22'h0, m_ram_addr});
    check_eq("ram_data", ram_data, m_ram_data);
    ga = 1'b0; gb = 1'b0; fa = 1'b0; fb = 1'b0;
    if (rst) begin
      if (ar && br) begin ga = m_last_b; gb = ~m_last_b; end
      else begin ga = ar; gb = br; end
      fa = ar;
      fb = br & ~ar;
    end
    check_eq("a_gnt", {31'h0, a_gnt}, {31'h0, ga});
    check_eq("b_gnt", {31'h0, b_gnt}, {31'h0, gb});
    check_eq("fp_a_gnt", {31'h0, fp_a_gnt}, {31'h0, fa});
    check_eq("fp_b_gnt", {31'h0, fp_b_gnt}, {31'h0, fb});
    if (!rst) begin
      m_last_b = 1'b1; m_ram_wr = 1'b0; m_ram_addr = 10'h0; m_ram_data = 32'h0;
    end else if (ga || gb) begin
      m_last_b   = gb;
      m_ram_wr   = ga ? aw : bw;
      m_ram_addr = ga ? aa : ba;
      m_ram_data = ga ? ad : bd;
      if (m_ram_wr) exp_mem[m_ram_addr] = m_ram_data;
      else exp_q.push_back('{port: gb, data: exp_mem[m_ram_addr], cyc: cyc});
    end else begin
      m_ram_wr = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic ga, gb;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, ga, gb);
  endtask

  initial begin
    logic ga, gb;
    logic [9:0] ap, bp;
    int a_seq, b_seq;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'hC0DE0000 ^ i;
      exp_mem[i] = 32'hC0DE0000 ^ i;
    end
    rst_n = 1'b0; a_req = 1'b0; a_wr = 1'b0; a_addr = 10'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = 10'h0; b_wdata = 32'h0;
    m_last_b = 1'b1; m_ram_wr = 1'b0; m_ram_addr = 10'h0; m_ram_data = 32'h0;
    @(posedge clk);
    #1;

    // reset with both requesting, then release: A must win first
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 1'b0, 10'h020, 32'h0, ga, gb);
    step(1'b1, 1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 1'b0, 10'h020, 32'h0, ga, gb);
    idle(4);

    // single port write then read-back
    step(1'b1, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0, 10'h0, 32'h0, ga, gb);
    step(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, ga, gb);
    idle(4);

    // contention: both read streams, addresses advance per accept
    ap = 10'h010; bp = 10'h020;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, ap, 32'h0, 1'b1, 1'b0, bp, 32'h0, ga, gb);
      if (ga) ap = ap + 10'h1;
      if (gb) bp = bp + 10'h1;
    end
    check_eq("rr_a_count", {22'h0, ap}, 32'h014);
    check_eq("rr_b_count", {22'h0, bp}, 32'h024);
    idle(4);

    // fixed priority view: long contention, then A drops
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 10'h040, 32'h0, 1'b1, 1'b0, 10'h050, 32'h0, ga, gb);
    step(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 10'h051, 32'h0, ga, gb);
    idle(4);

    // ordering: write at top address, then B reads it
    step(1'b1, 1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b0, 1'b0, 10'h0, 32'h0, ga, gb);
    step(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 10'h3FF, 32'h0, ga, gb);
    idle(2);
    // same-cycle write A / read B at one address, B held until served
    step(1'b1, 1'b1, 1'b1, 10'h3FE, 32'hA5A55A5A, 1'b1, 1'b0, 10'h3FE, 32'h0, ga, gb);
    if (!gb) step(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 10'h3FE, 32'h0, ga, gb);
    idle(4);

    // reset while a B read is in flight
    step(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b0, 10'h060, 32'h0, ga, gb);
    step(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, ga, gb);
    idle(5);

    // random mix over a small address window
    a_seq = 0; b_seq = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 10'h100 + 10'($urandom_range(7, 0)),
           32'h0A000000 + a_seq, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           10'h100 + 10'($urandom_range(7, 0)), 32'h0B000000 + b_seq, ga, gb);
      if (ga) a_seq++;
      if (gb) b_seq++;
    end
    idle(5);
    check_eq("drain", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
